fp_unary_arbiter: RTL

- Shares one pipelined FP32 sign-manipulation unit (PASS/ABS/NEG/NABS) between NUM_REQ requesters, such as TPU vector lanes and the activation post-processor.
- Arbitration is round-robin with valid/ready request handshakes.
- Each requester has a one-entry response register with its own valid/ready handshake.
- Results are bit-exact IEEE-754 single precision; only bit 31 is modified.

---
 rtl/fp_unary_pkg.sv | 36 +++
 rtl/fp_unary_arbiter_sign.sv | 25 ++
 rtl/fp_unary_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fp_unary_pkg.sv
// Shared types for the FP32 unary sign-manipulation arbiter.
//   fp32_t        raw IEEE-754 single-precision word
//   FP_SIGN_BIT   position of the sign bit (the only bit any op touches)
//   fp_op_e       PASS / ABS / NEG / NABS
//   slot_state_e  per-requester slot lifecycle
//   pipe_stage_t  one pipeline stage register {valid, id, op, data}
package fp_unary_pkg;

  typedef logic [31:0] fp32_t;

  localparam int FP_SIGN_BIT = 31;

  // Requester id field is sized for the largest supported NUM_REQ (8).
  localparam int ID_W = 3;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_ABS  = 2'b01,
    OP_NEG  = 2'b10,
    OP_NABS = 2'b11
  } fp_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    INFLIGHT = 2'b01,
    HOLD     = 2'b10
  } slot_state_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    fp_op_e          op;
    fp32_t           data;
  } pipe_stage_t;

endpackage

// File: rtl/fp_unary_arbiter_sign.sv
// fp_sign_unit: combinational FP32 sign manipulation.
//   op  in   fp_op_e encoding (PASS/ABS/NEG/NABS)
//   a   in   FP32 operand
//   y   out  FP32 result; bits 30:0 always equal a[30:0]
// NaN, Inf, denormals and zeros are treated as plain bit patterns.
module fp_sign_unit
  import fp_unary_pkg::*;
(
  input  logic [1:0] op,
  input  fp32_t      a,
  output fp32_t      y
);

  always_comb begin
    y = a;
    unique case (fp_op_e'(op))
      OP_PASS: y[FP_SIGN_BIT] = a[FP_SIGN_BIT];
      OP_ABS:  y[FP_SIGN_BIT] = 1'b0;
      OP_NEG:  y[FP_SIGN_BIT] = ~a[FP_SIGN_BIT];
      OP_NABS: y[FP_SIGN_BIT] = 1'b1;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/fp_unary_arbiter.sv
// fp_unary_arbiter: round-robin sharing of one pipelined FP32 sign unit
// between NUM_REQ requesters, each with a one-entry response register.
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   per-requester request present
//   req_op       in   per-requester fp_op_e
//   req_data     in   per-requester FP32 operand
//   req_ready    out  one-hot grant (accept on valid & ready)
//   resp_valid   out  per-requester result held
//   resp_ready   in   per-requester result consumed
//   resp_data    out  per-requester FP32 result (holds last value)
//   busy         out  any requester slot not IDLE
//   stat_grants  out  saturating per-requester grant counters
// Build option: define FPU_ARB_STATS_EN to add stat_grants and its counters.
module fp_unary_arbiter
  import fp_unary_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LAT     = 2,
  parameter int STAT_W  = 16
)
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][1:0]         req_op,
  input  logic [NUM_REQ-1:0][31:0]        req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              resp_valid,
  input  logic [NUM_REQ-1:0]              resp_ready,
  output logic [NUM_REQ-1:0][31:0]        resp_data,
  output logic                            busy
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][STAT_W-1:0]  stat_grants
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [NUM_REQ-1:0] idle_vec, hold_vec, land_vec, eligible, grant;
  logic               grant_any, accept;
  logic [IDX_W-1:0]   grant_idx;
  pipe_stage_t        pipe_reg [LAT];
  pipe_stage_t        pipe_last, stage_in;
  fp32_t              sign_out;

  assign eligible = req_valid & idle_vec;

  // Round-robin pick: first eligible index at or above rr_ptr, otherwise
  // the first eligible index below it (the wrap-around part of the search).
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && eligible[i] && (i >= int'(rr_ptr_reg))) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(i);
        grant[i]  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && eligible[i] && (i < int'(rr_ptr_reg))) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(i);
        grant[i]  = 1'b1;
      end
    end
  end

  // Grant is combinational on req_valid; masking with rst_n keeps req_ready
  // low for the whole time reset is held.
  assign accept    = grant_any & rst_n;
  assign req_ready = rst_n ? grant : '0;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (accept) begin
      rr_ptr_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_reg <= '0;
    else        rr_ptr_reg <= rr_ptr_next;
  end

  // The op is applied on the way into stage 1; later stages just carry data.
  fp_sign_unit u_sign (
    .op (req_op[grant_idx]),
    .a  (req_data[grant_idx]),
    .y  (sign_out)
  );

  always_comb begin
    stage_in       = '0;
    stage_in.valid = accept;
    stage_in.id    = ID_W'(grant_idx);
    stage_in.op    = fp_op_e'(req_op[grant_idx]);
    stage_in.data  = sign_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) pipe_reg[s] <= '0;
    end else begin
      pipe_reg[0] <= stage_in;
      for (int s = 1; s < LAT; s++) pipe_reg[s] <= pipe_reg[s-1];
    end
  end

  assign pipe_last = pipe_reg[LAT-1];

  // Per-requester slot FSM. Only IDLE slots may be granted, so a landing
  // result always finds its response register free.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    slot_state_e slot_reg, slot_next;

    assign land_vec[gi] = pipe_last.valid && (pipe_last.id == ID_W'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) slot_reg <= IDLE;
      else        slot_reg <= slot_next;
    end

    always_comb begin
      slot_next = slot_reg;
      unique case (slot_reg)
        IDLE:     if (accept && grant[gi]) slot_next = INFLIGHT;
        INFLIGHT: if (land_vec[gi])        slot_next = HOLD;
        HOLD:     if (resp_ready[gi])      slot_next = IDLE;
        default:                           slot_next = IDLE;
      endcase
    end

    assign idle_vec[gi] = (slot_reg == IDLE);
    assign hold_vec[gi] = (slot_reg == HOLD);
  end

  assign resp_valid = hold_vec;
  assign busy       = |(~idle_vec);

  // Response registers load only when a result lands, so they stay stable
  // through HOLD and keep their last value afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (land_vec[i]) resp_data[i] <= pipe_last.data;
      end
    end
  end

`ifdef FPU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && grant[i] && (stat_grants[i] != {STAT_W{1'b1}})) begin
          stat_grants[i] <= stat_grants[i] + 1'b1;
        end
      end
    end
  end
`endif

endmodule
